// File: rtl/trap_flush_ctrl_if.sv
// Commit, interrupt, debug, flush-handshake and CSR-update signals of trap_flush_ctrl.
// master = the controller side, slave = the surrounding pipeline (EXU/IFU/CSR file).
interface trap_flush_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int N_IRQ  = 3
);
  logic [N_IRQ-1:0]  irq_pend_i;
  logic [N_IRQ-1:0]  irq_en_i;
  logic              status_mie_i;
  logic [ADDR_W-1:0] mtvec_i;
  logic [ADDR_W-1:0] mepc_i;
  logic              cmt_vld_i;
  logic [ADDR_W-1:0] cmt_pc_i;
  logic [ADDR_W-1:0] cmt_jaddr_i;
  logic              cmt_taken_i;
  logic              cmt_prdt_i;
  logic              cmt_mret_i;
  logic              cmt_exc_i;
  logic [4:0]        cmt_exc_code_i;
  logic [ADDR_W-1:0] cmt_tval_i;
  logic              dbg_halt_i;
  logic              dbg_rst_i;
  logic              flush_ack_i;
  logic              flush_req_o;
  logic [ADDR_W-1:0] flush_addr_o;
  logic              flush_comb_o;
  logic              cmt_stall_o;
  logic              halted_o;
  logic [ADDR_W-1:0] csr_epc_o;
  logic [ADDR_W-1:0] csr_cause_o;
  logic [ADDR_W-1:0] csr_tval_o;
  logic              csr_epc_we_o;
  logic              csr_cause_we_o;
  logic              csr_tval_we_o;
  logic              csr_trap_o;
  logic              csr_mret_o;
  logic [1:0]        state_o;

  // Flush handshake: flush_req_o/flush_addr_o hold steady until a cycle in
  // which flush_ack_i is sampled high; that edge completes the transfer.
  modport master (
    input  irq_pend_i, irq_en_i, status_mie_i, mtvec_i, mepc_i,
           cmt_vld_i, cmt_pc_i, cmt_jaddr_i, cmt_taken_i, cmt_prdt_i,
           cmt_mret_i, cmt_exc_i, cmt_exc_code_i, cmt_tval_i,
           dbg_halt_i, dbg_rst_i, flush_ack_i,
    output flush_req_o, flush_addr_o, flush_comb_o, cmt_stall_o, halted_o,
           csr_epc_o, csr_cause_o, csr_tval_o, csr_epc_we_o, csr_cause_we_o,
           csr_tval_we_o, csr_trap_o, csr_mret_o, state_o
  );

  modport slave (
    output irq_pend_i, irq_en_i, status_mie_i, mtvec_i, mepc_i,
           cmt_vld_i, cmt_pc_i, cmt_jaddr_i, cmt_taken_i, cmt_prdt_i,
           cmt_mret_i, cmt_exc_i, cmt_exc_code_i, cmt_tval_i,
           dbg_halt_i, dbg_rst_i, flush_ack_i,
    input  flush_req_o, flush_addr_o, flush_comb_o, cmt_stall_o, halted_o,
           csr_epc_o, csr_cause_o, csr_tval_o, csr_epc_we_o, csr_cause_we_o,
           csr_tval_we_o, csr_trap_o, csr_mret_o, state_o
  );
endinterface

// File: rtl/trap_flush_ctrl.sv
// Commit-stage trap/flush controller: arbitrates debug, exceptions, mret,
// interrupts and mispredicts into one held flush request plus CSR trap writes.
module trap_flush_ctrl #(
  parameter int                ADDR_W    = 32,
  parameter int                N_IRQ     = 3,
  parameter logic [8*N_IRQ-1:0] IRQ_CODES = {8'd11, 8'd3, 8'd7},
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  trap_flush_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] np_q;
  logic [ADDR_W-1:0] flush_addr_q;
  logic              flush_req_q;
  logic              halted_q;

  logic              in_run;
  logic              cmt_acc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] trap_base;
  logic [ADDR_W-1:0] irq_tgt;
  logic [ADDR_W-1:0] misp_tgt;
  logic [N_IRQ-1:0]  irq_act;
  logic [7:0]        irq_code;
  logic              exc_ev, mret_ev, irq_ev, misp_ev;

  logic              take_flush;
  logic [ADDR_W-1:0] flush_tgt;
  logic              epc_we, cause_we, tval_we, trap_stb, mret_stb;
  logic [ADDR_W-1:0] epc_val, cause_val, tval_val;

  assign in_run    = (state_q == S_RUN);
  assign cmt_acc   = bus.cmt_vld_i & in_run;
  assign pc_plus4  = bus.cmt_pc_i + ADDR_W'(4);
  assign seq_pc    = bus.cmt_taken_i ? bus.cmt_jaddr_i : pc_plus4;
  assign next_pc   = cmt_acc ? seq_pc : np_q;
  assign trap_base = {bus.mtvec_i[ADDR_W-1:2], 2'b00};
  assign misp_tgt  = bus.cmt_prdt_i ? pc_plus4 : bus.cmt_jaddr_i;
  assign irq_act   = bus.irq_pend_i & bus.irq_en_i;

  // Ascending scan: the last (highest-index) active source wins.
  always_comb begin
    irq_code = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (irq_act[i]) irq_code = IRQ_CODES[i*8 +: 8];
    end
  end

  assign irq_tgt = (bus.mtvec_i[1:0] == 2'b01) ? trap_base + (ADDR_W'(irq_code) << 2)
                                               : trap_base;

  assign exc_ev  = cmt_acc & bus.cmt_exc_i;
  assign mret_ev = cmt_acc & bus.cmt_mret_i;
  assign irq_ev  = in_run & (|irq_act) & bus.status_mie_i;
  assign misp_ev = cmt_acc & (bus.cmt_taken_i ^ bus.cmt_prdt_i);

  always_comb begin
    take_flush = 1'b0;
    flush_tgt  = flush_addr_q;
    epc_we     = 1'b0;
    cause_we   = 1'b0;
    tval_we    = 1'b0;
    trap_stb   = 1'b0;
    mret_stb   = 1'b0;
    epc_val    = '0;
    cause_val  = '0;
    tval_val   = '0;
    case (state_q)
      S_RUN: begin
        if (bus.dbg_rst_i) begin
          take_flush = 1'b1;
          flush_tgt  = RESET_PC;
        end else if (bus.dbg_halt_i) begin
          take_flush = 1'b0;
        end else if (exc_ev) begin
          take_flush = 1'b1;
          flush_tgt  = trap_base;
          epc_we     = 1'b1;
          cause_we   = 1'b1;
          tval_we    = 1'b1;
          trap_stb   = 1'b1;
          epc_val    = bus.cmt_pc_i;
          cause_val  = {{(ADDR_W-5){1'b0}}, bus.cmt_exc_code_i};
          tval_val   = bus.cmt_tval_i;
        end else if (mret_ev) begin
          take_flush = 1'b1;
          flush_tgt  = bus.mepc_i;
          mret_stb   = 1'b1;
        end else if (irq_ev) begin
          take_flush = 1'b1;
          flush_tgt  = irq_tgt;
          epc_we     = 1'b1;
          cause_we   = 1'b1;
          trap_stb   = 1'b1;
          epc_val    = next_pc;
          cause_val  = {1'b1, {(ADDR_W-9){1'b0}}, irq_code};
        end else if (misp_ev) begin
          take_flush = 1'b1;
          flush_tgt  = misp_tgt;
        end
      end
      S_HALT: begin
        if (bus.dbg_rst_i) begin
          take_flush = 1'b1;
          flush_tgt  = RESET_PC;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RUN;
      np_q         <= RESET_PC;
      flush_req_q  <= 1'b0;
      flush_addr_q <= RESET_PC;
      halted_q     <= 1'b0;
    end else begin
      if (cmt_acc) np_q <= seq_pc;
      case (state_q)
        S_RUN: begin
          if (take_flush) begin
            state_q      <= S_FLUSH;
            flush_req_q  <= 1'b1;
            flush_addr_q <= flush_tgt;
          end else if (bus.dbg_halt_i) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
        end
        S_FLUSH: begin
          // A debug reset retargets the pending flush, even if the old target was just acked.
          if (bus.dbg_rst_i) begin
            flush_addr_q <= RESET_PC;
          end else if (bus.flush_ack_i) begin
            state_q     <= S_RUN;
            flush_req_q <= 1'b0;
          end
        end
        S_HALT: begin
          if (take_flush) begin
            state_q      <= S_FLUSH;
            flush_req_q  <= 1'b1;
            flush_addr_q <= flush_tgt;
            halted_q     <= 1'b0;
          end else if (!bus.dbg_halt_i) begin
            state_q  <= S_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_RUN;
          flush_req_q <= 1'b0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flush_req_o    = flush_req_q;
  assign bus.flush_addr_o   = flush_addr_q;
  assign bus.flush_comb_o   = take_flush;
  assign bus.cmt_stall_o    = ~in_run;
  assign bus.halted_o       = halted_q;
  assign bus.csr_epc_o      = epc_val;
  assign bus.csr_cause_o    = cause_val;
  assign bus.csr_tval_o     = tval_val;
  assign bus.csr_epc_we_o   = epc_we;
  assign bus.csr_cause_we_o = cause_we;
  assign bus.csr_tval_we_o  = tval_we;
  assign bus.csr_trap_o     = trap_stb;
  assign bus.csr_mret_o     = mret_stb;
  assign bus.state_o        = state_q;

endmodule

// File: doc/trap_flush_ctrl.md
# trap_flush_ctrl

Parametrised commit-stage trap and flush controller for the RV core pipeline: second-generation pipe control. Sits after the EXU commit point; arbitrates debug reset/halt, synchronous exceptions, mret, N prioritised interrupt sources and branch mispredicts into a single flush request to the IFU. Drives the machine-mode CSR trap updates (mepc/mcause/mtval/mstatus). Adds a flush_ack handshake, vectored mtvec and a HALT state.

## Interface
- ADDR_W, 32, address/data width
- N_IRQ, 3, number of interrupt sources; index N_IRQ-1 highest priority
- IRQ_CODES, {8'd11,8'd3,8'd7}, packed 8-bit mcause codes per source, index 0 in LSBs (default: ext > soft > timer)
- RESET_PC, 32'h8000_0000, debug-reset target; reset value of flush_addr_o
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- irq_pend_i  in  N_IRQ  pending interrupt lines (level)
- irq_en_i  in  N_IRQ  mie enable bits
- status_mie_i  in  1  mstatus.MIE
- mtvec_i, mepc_i  in  ADDR_W  CSR values; mtvec_i[1:0]=1 selects vectored
- cmt_vld_i  in  1  instruction commits this cycle
- cmt_pc_i, cmt_jaddr_i  in  ADDR_W  committing PC, resolved branch target
- cmt_taken_i, cmt_prdt_i  in  1  branch actually taken / predicted taken
- cmt_mret_i  in  1  committing instruction is mret
- cmt_exc_i  in  1  committing instruction raised an exception
- cmt_exc_code_i  in  5  exception cause code
- cmt_tval_i  in  ADDR_W  exception mtval
- dbg_halt_i, dbg_rst_i  in  1  debug halt (level), debug reset request (level)
- flush_ack_i  in  1  IFU accepted the flush
- flush_req_o  out  1  registered flush request, held until acked
- flush_addr_o  out  ADDR_W  registered redirect target
- flush_comb_o  out  1  unregistered: event accepted this cycle (OITF kill)
- cmt_stall_o  out  1  EXU must not commit
- halted_o  out  1  in HALT state
- csr_epc_o, csr_cause_o, csr_tval_o  out  ADDR_W  CSR write data
- csr_epc_we_o, csr_cause_we_o, csr_tval_we_o, csr_trap_o, csr_mret_o  out  1  single-cycle write strobes

## Operation
- Next-PC tracker np_r: on each accepted commit, np_r <= cmt_taken_i ? cmt_jaddr_i : cmt_pc_i+4. next_pc = accepted commit ? that value : np_r.
- Commit accepted = cmt_vld_i & ~cmt_stall_o; all cmt_* ignored otherwise.
- irq_hit = |(irq_pend_i & irq_en_i) & status_mie_i; winner = highest set index.
- Mispredict = accepted commit & (cmt_taken_i ^ cmt_prdt_i); target = cmt_prdt_i ? cmt_pc_i+4 : cmt_jaddr_i.
- Priority in RUN: dbg_rst > dbg_halt > exception > mret > interrupt > mispredict. Lower events in the same cycle are dropped (the interrupt stays pending and is retaken).
- Trap base = {mtvec_i[ADDR_W-1:2],2'b00}. Exception target = base. Interrupt target = base + 4*code if vectored, else base. mret target = mepc_i. dbg_rst target = RESET_PC.
- Exception: epc = cmt_pc_i, cause = {0, code}, tval = cmt_tval_i; epc/cause/tval/trap strobes.
- Interrupt: epc = next_pc, cause = {1, zero-extended code}; epc/cause/trap strobes, tval_we=0.
- mret: csr_mret_o only. Mispredict and dbg_rst: no CSR strobes.
- States: RUN, FLUSH, HALT.
  - RUN: a flush event -> FLUSH. dbg_halt_i (no dbg_rst) -> HALT.
  - FLUSH: flush_req_o=1, addr stable; flush_ack_i -> RUN. dbg_rst_i while in FLUSH overwrites the address with RESET_PC and stays in FLUSH. All other events are ignored.
  - HALT: interrupts masked, no flush. dbg_halt_i low -> RUN. dbg_rst_i -> FLUSH to RESET_PC.
- cmt_stall_o = state != RUN.

## Timing
- Reset: state RUN, np_r=RESET_PC, flush_req_o=0, flush_addr_o=RESET_PC, halted_o=0; all strobes and flush_comb_o are 0.
- Event in cycle T: flush_comb_o and CSR strobes are combinational in T. flush_req_o and flush_addr_o are valid from T+1, held until the cycle flush_ack_i=1 is sampled. flush_req_o falls the cycle after the ack.
- flush_req_o and flush_ack_i high in the same cycle: the flush completes; state is RUN at the next edge, and a new event may be taken from that cycle.
- halted_o rises one cycle after dbg_halt_i is sampled in RUN and falls one cycle after release.
- Address arithmetic is modulo 2^ADDR_W; pc+4 and vectored offsets wrap silently.
- Asynchronous reset mid-FLUSH drops the request immediately.

## Test plan
- Mispredict: commit pc=0x100, taken=1, prdt=0, jaddr=0x200 -> flush_comb_o in T; flush_req_o with addr 0x200 from T+1 until ack; no CSR strobes.
- Vectored timer interrupt: mtvec=0x1001, pend/en bit0, MIE=1, no commit, np_r=0x204 -> epc 0x204, cause 0x8000_0007, addr 0x101C.
- Exception + interrupt same cycle: exc code 2, pc 0x300, tval 0xDEAD -> exception wins: epc 0x300, cause 2, tval 0xDEAD; interrupt taken after the ack.
- Two irqs (ext and timer) pending, direct mtvec 0x1000 -> cause 0x8000_000B, addr 0x1000.
- Halt: dbg_halt_i during RUN -> halted_o=1, cmt_stall_o=1, irq ignored; dbg_rst_i -> flush to 0x8000_0000.
- Ack delay: hold flush_ack_i low 5 cycles -> flush_req_o and addr stable, commits blocked; dbg_rst mid-wait -> addr becomes RESET_PC.
